// File: rtl/rob_retire_buffer.sv
// Reorder buffer with in-order retirement.
// Dispatch allocates entries at the tail, one per cycle. Writeback marks them
// complete by tag. Completed entries retire from the head in program order,
// and each retirement hands pd_old back to the free list. A flush or a reset
// empties the buffer. Full and empty have the same head==tail pointer
// relationship, so the occupancy count is the only thing that tells them apart.
module rob_retire_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int PREG_W = 7,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic              alloc_has_rd,
  input  logic [31:0]       alloc_pc,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic [PREG_W-1:0] retire_pd_new,
  output logic              retire_has_rd,
  output logic [31:0]       retire_pc,
  output logic [TAG_W-1:0]  retire_tag,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  cmpl_q, cmpl_d;
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_new_d [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];
  logic [PREG_W-1:0] pd_old_d [DEPTH];
  logic [DEPTH-1:0]  has_rd_q, has_rd_d;
  logic [31:0]       pc_q [DEPTH];
  logic [31:0]       pc_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic alloc_fire;
  logic retire_fire;

  // alloc_ready comes only from the registered count, so there is no path from
  // retire_ready. A full buffer stalls allocation even while a retire fires.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  // The head entry is presented combinationally. Because retire_valid uses only
  // registered bits, the head fields stay stable while retire_ready is low.
  assign retire_valid  = valid_q[head_q] && cmpl_q[head_q];
  assign retire_tag    = head_q;
  assign retire_pd_old = pd_old_q[head_q];
  assign retire_pd_new = pd_new_q[head_q];
  assign retire_has_rd = has_rd_q[head_q];
  assign retire_pc     = pc_q[head_q];

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire_fire = retire_valid && retire_ready;

  // Next-state update: flush wins over everything, otherwise complete/retire/allocate
  always_comb begin
    valid_d  = valid_q;
    cmpl_d   = cmpl_q;
    pd_new_d = pd_new_q;
    pd_old_d = pd_old_q;
    has_rd_d = has_rd_q;
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      valid_d = '0;
      cmpl_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // A completion to an empty slot is stale and is ignored.
      if (cmpl_valid && valid_q[cmpl_tag]) begin
        cmpl_d[cmpl_tag] = 1'b1;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        cmpl_d[head_q]  = 1'b0;
        head_d          = head_q + TAG_W'(1);
      end
      // The tail slot is free whenever allocation fires. A completion aimed at
      // it has already been dropped above, so it cannot collide with this write.
      if (alloc_fire) begin
        valid_d[tail_q]  = 1'b1;
        cmpl_d[tail_q]   = 1'b0;
        pd_new_d[tail_q] = alloc_pd_new;
        pd_old_d[tail_q] = alloc_pd_old;
        has_rd_d[tail_q] = alloc_has_rd;
        pc_d[tail_q]     = alloc_pc;
        tail_d           = tail_q + TAG_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
    end
  end

  // State register; reset also clears the entry payloads
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      cmpl_q   <= '0;
      has_rd_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pd_new_q[i] <= '0;
        pd_old_q[i] <= '0;
        pc_q[i]     <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      cmpl_q   <= cmpl_d;
      has_rd_q <= has_rd_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      pd_new_q <= pd_new_d;
      pd_old_q <= pd_old_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Testbench for rob_retire_buffer.
// The reference model is a program-order queue of in-flight instructions.
// Directed scenarios carry hand-computed expectations, and a randomized phase
// is checked against the model on every cycle.
module tb_rob_retire_buffer;
  localparam int DEPTH  = 16;
  localparam int PREG_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_pd_new = '0;
  logic [PREG_W-1:0] alloc_pd_old = '0;
  logic              alloc_has_rd = 1'b0;
  logic [31:0]       alloc_pc = '0;
  logic [3:0]        alloc_tag;
  logic              cmpl_valid = 1'b0;
  logic [3:0]        cmpl_tag = '0;
  logic              retire_valid;
  logic              retire_ready = 1'b0;
  logic [PREG_W-1:0] retire_pd_old, retire_pd_new;
  logic              retire_has_rd;
  logic [31:0]       retire_pc;
  logic [3:0]        retire_tag;
  logic              flush = 1'b0;
  logic [4:0]        count;
  logic              empty, full;

  always #5 clk = ~clk;

  rob_retire_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
    .alloc_has_rd(alloc_has_rd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_pd_old(retire_pd_old), .retire_pd_new(retire_pd_new),
    .retire_has_rd(retire_has_rd), .retire_pc(retire_pc), .retire_tag(retire_tag),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    int          tag;
    int          pd_new;
    int          pd_old;
    int          has_rd;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  typedef struct {
    int tag;
    int pd_old;
    int cyc;
  } ret_t;

  ent_t m_q[$];
  int   m_tail = 0;
  int   m_head = 0;
  ret_t log_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   exp_rv, m_afire, m_rfire;
  ent_t new_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with the inputs
  // that the next rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    exp_rv = (m_q.size() > 0) && m_q[0].done;
    if (!reset) begin
      chk("m_alloc_ready", alloc_ready, m_q.size() < DEPTH);
      chk("m_alloc_tag", alloc_tag, m_tail);
      chk("m_count", count, m_q.size());
      chk("m_empty", empty, m_q.size() == 0);
      chk("m_full", full, m_q.size() == DEPTH);
      chk("m_retire_valid", retire_valid, exp_rv);
      chk("m_retire_tag", retire_tag, m_head);
      if (exp_rv && retire_valid) begin
        chk("m_retire_pd_old", retire_pd_old, m_q[0].pd_old);
        chk("m_retire_pd_new", retire_pd_new, m_q[0].pd_new);
        chk("m_retire_has_rd", retire_has_rd, m_q[0].has_rd);
        chk("m_retire_pc", retire_pc, m_q[0].pc);
      end
      if (retire_valid && retire_ready && !flush)
        log_q.push_back('{tag: int'(retire_tag), pd_old: int'(retire_pd_old), cyc: cyc});
    end
    if (reset || flush) begin
      m_q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      m_afire = alloc_valid && (m_q.size() < DEPTH);
      m_rfire = exp_rv && retire_ready;
      if (cmpl_valid)
        for (int i = 0; i < m_q.size(); i++)
          if (m_q[i].tag == int'(cmpl_tag)) m_q[i].done = 1'b1;
      if (m_rfire) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (m_afire) begin
        new_e.tag    = m_tail;
        new_e.pd_new = int'(alloc_pd_new);
        new_e.pd_old = int'(alloc_pd_old);
        new_e.has_rd = int'(alloc_has_rd);
        new_e.pc     = alloc_pc;
        new_e.done   = 1'b0;
        m_q.push_back(new_e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid  = 1'b0;
    cmpl_valid   = 1'b0;
    retire_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic alloc(input int pdo, input logic [31:0] pc);
    alloc_valid  = 1'b1;
    alloc_pd_old = PREG_W'(pdo);
    alloc_pd_new = PREG_W'($urandom_range(0, 127));
    alloc_has_rd = 1'($urandom_range(0, 1));
    alloc_pc     = pc;
    tick();
    alloc_valid  = 1'b0;
  endtask

  task automatic complete(input int t);
    cmpl_valid = 1'b1;
    cmpl_tag   = 4'(t);
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    retire_ready = 1'b1;
    while (!empty && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_bound", empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values and idle
    do_reset();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_tag", retire_tag, 0);
    chk("rst_retire_pd_old", retire_pd_old, 0);
    chk("rst_retire_pd_new", retire_pd_new, 0);
    chk("rst_retire_has_rd", retire_has_rd, 0);
    chk("rst_retire_pc", retire_pc, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", alloc_ready, 1);
      chk("idle_empty", empty, 1);
      chk("idle_count", count, 0);
      chk("idle_rv", retire_valid, 0);
    end

    // in-order flow
    do_reset();
    for (int i = 0; i < 3; i++) alloc(10 + i, 32'h100 + 32'(4 * i));
    retire_ready = 1'b1;
    for (int i = 0; i < 3; i++) complete(i);
    tick(); tick(); tick();
    retire_ready = 1'b0;
    chk("inord_nret", log_q.size(), 3);
    if (log_q.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("inord_pd_old", log_q[k].pd_old, 10 + k);
        chk("inord_consec", log_q[k].cyc, log_q[0].cyc + k);
      end
    chk("inord_empty", empty, 1);

    // out-of-order completion
    do_reset();
    for (int i = 0; i < 4; i++) alloc(20 + i, 32'h200 + 32'(4 * i));
    retire_ready = 1'b1;
    complete(3); complete(2); complete(1);
    chk("ooo_rv_held", retire_valid, 0);
    chk("ooo_none_ret", log_q.size(), 0);
    complete(0);
    for (int i = 0; i < 5; i++) tick();
    retire_ready = 1'b0;
    chk("ooo_nret", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("ooo_tag", log_q[k].tag, k);
        chk("ooo_consec", log_q[k].cyc, log_q[0].cyc + k);
      end

    // full and wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(i, 32'h1000 + 32'(i));
    chk("full_full", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    complete(0);
    alloc_valid = 1'b1;
    retire_ready = 1'b1;
    tick();
    alloc_valid = 1'b0;
    retire_ready = 1'b0;
    chk("full_stall_count", count, 15);
    chk("full_stall_tag", alloc_tag, 0);
    retire_ready = 1'b1;
    complete(1); complete(2); complete(3);
    tick();
    retire_ready = 1'b0;
    chk("wrap_count12", count, 12);
    chk("wrap_head", retire_tag, 4);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_alloc_tag", alloc_tag, k);
      alloc(40 + k, 32'h2000 + 32'(k));
    end
    chk("wrap_count16", count, 16);
    log_q.delete();
    retire_ready = 1'b1;
    for (int k = 3; k >= 0; k--) complete(k);
    for (int k = 15; k >= 4; k--) complete(k);
    drain(40);
    retire_ready = 1'b0;
    chk("wrap_nret", log_q.size(), 16);
    if (log_q.size() == 16)
      for (int k = 0; k < 16; k++) chk("wrap_order", log_q[k].tag, (4 + k) % 16);

    // backpressure
    do_reset();
    alloc(5, 32'h1234_5678);
    complete(0);
    retire_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rv", retire_valid, 1);
      chk("bp_pc", retire_pc, 32'h1234_5678);
      tick();
    end
    chk("bp_none_ret", log_q.size(), 0);
    retire_ready = 1'b1;
    tick();
    retire_ready = 1'b0;
    chk("bp_nret", log_q.size(), 1);
    if (log_q.size() == 1) chk("bp_pd_old", log_q[0].pd_old, 5);
    chk("bp_count", count, 0);

    // flush mid-handshake
    do_reset();
    for (int i = 0; i < 6; i++) alloc(30 + i, 32'h300 + 32'(i));
    complete(1); complete(0);
    chk("fl_pre_count", count, 6);
    chk("fl_pre_rv", retire_valid, 1);
    flush = 1'b1;
    alloc_valid = 1'b1;
    retire_ready = 1'b1;
    cmpl_valid = 1'b1;
    cmpl_tag = 4'd2;
    tick();
    idle_inputs();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_alloc_tag", alloc_tag, 0);
    chk("fl_rv", retire_valid, 0);
    chk("fl_head", retire_tag, 0);
    tick();
    chk("fl_count2", count, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      alloc_valid  = ($urandom_range(0, 99) < 60);
      alloc_pd_new = PREG_W'($urandom_range(0, 127));
      alloc_pd_old = PREG_W'($urandom_range(0, 127));
      alloc_has_rd = 1'($urandom_range(0, 1));
      alloc_pc     = $urandom();
      cmpl_valid   = ($urandom_range(0, 99) < 60);
      cmpl_tag     = 4'($urandom_range(0, 15));
      retire_ready = ($urandom_range(0, 99) < ((i % 1000) < 500 ? 30 : 85));
      flush        = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
